mrv1_wb_arb: RTL and testbench

//  Writeback arbiter between the exec functional units (INT, MUL, MEM, SYS) and the single register-file write port.

---
 rtl/mrv1_wb_arb.sv | 149 ++++++++++++++
 tb/tb_mrv1_wb_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mrv1_wb_arb.sv
// Writeback arbiter: per-FU result FIFOs drained round-robin into the single
// register-file write port, with registered issue stalls and sticky overflow flags.
module mrv1_wb_arb #(
    parameter int NUM_FU_P      = 4,
    parameter int DATA_WIDTH_P  = 32,
    parameter int ITAG_WIDTH_P  = 3,
    parameter int NUM_THREADS_P = 8,
    parameter int FIFO_DEPTH_P  = 2,
    parameter int SLACK_P       = 1,
    parameter int TID_WIDTH_LP  = $clog2(NUM_THREADS_P),
    parameter int FU_IDX_W_LP   = (NUM_FU_P > 1) ? $clog2(NUM_FU_P) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_FU_P-1:0]              fu_done_i,
    input  logic [NUM_FU_P*DATA_WIDTH_P-1:0] fu_res_data_i,
    input  logic [NUM_FU_P*ITAG_WIDTH_P-1:0] fu_itag_i,
    input  logic [NUM_FU_P*TID_WIDTH_LP-1:0] fu_tid_i,
    output logic [NUM_FU_P-1:0]              fu_wb_stall_o,
    output logic                             wb_vld_o,
    input  logic                             wb_rdy_i,
    output logic [DATA_WIDTH_P-1:0]          wb_data_o,
    output logic [ITAG_WIDTH_P-1:0]          wb_itag_o,
    output logic [TID_WIDTH_LP-1:0]          wb_tid_o,
    output logic [FU_IDX_W_LP-1:0]           wb_fu_o,
    output logic [NUM_FU_P-1:0]              ovf_err_o
);
    // Handshake: a writeback transfers on any cycle where wb_vld_o & wb_rdy_i;
    // wb_vld_o is a pure function of FIFO occupancy, and once raised the
    // presented entry is held stable until it transfers.
    localparam int PTR_W = (FIFO_DEPTH_P > 1) ? $clog2(FIFO_DEPTH_P) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH_P + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH_P);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FIFO_DEPTH_P - SLACK_P);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH_P - 1);
    localparam logic [FU_IDX_W_LP-1:0] LAST_FU = FU_IDX_W_LP'(NUM_FU_P - 1);

    logic [DATA_WIDTH_P-1:0] mem_data [NUM_FU_P][FIFO_DEPTH_P];
    logic [ITAG_WIDTH_P-1:0] mem_itag [NUM_FU_P][FIFO_DEPTH_P];
    logic [TID_WIDTH_LP-1:0] mem_tid  [NUM_FU_P][FIFO_DEPTH_P];

    logic [PTR_W-1:0]        rd_ptr   [NUM_FU_P];
    logic [PTR_W-1:0]        wr_ptr   [NUM_FU_P];
    logic [CNT_W-1:0]        cnt      [NUM_FU_P];
    logic [CNT_W-1:0]        cnt_next [NUM_FU_P];
    logic [NUM_FU_P-1:0]     nonempty, push, pop, drop;
    logic [NUM_FU_P-1:0]     stall_q, ovf_q;
    logic [FU_IDX_W_LP-1:0]  rr_ptr, lock_idx, scan_idx, grant, grant_inc;
    logic                    lock, hs;
    logic [DATA_WIDTH_P-1:0] head_data, hold_data;
    logic [ITAG_WIDTH_P-1:0] head_itag, hold_itag;
    logic [TID_WIDTH_LP-1:0] head_tid, hold_tid;
    logic [FU_IDX_W_LP-1:0]  hold_fu;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int j;
        j        = 0;
        scan_idx = rr_ptr;
        for (int k = NUM_FU_P - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NUM_FU_P;
            if (nonempty[j]) scan_idx = FU_IDX_W_LP'(j);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU_P; i++) nonempty[i] = (cnt[i] != '0);
        grant     = lock ? lock_idx : scan_idx;
        grant_inc = (grant == LAST_FU) ? '0 : grant + FU_IDX_W_LP'(1);
        wb_vld_o  = |nonempty;
        hs        = wb_vld_o & wb_rdy_i;
        head_data = mem_data[grant][rd_ptr[grant]];
        head_itag = mem_itag[grant][rd_ptr[grant]];
        head_tid  = mem_tid[grant][rd_ptr[grant]];
    end

    // A full FIFO still accepts a result when its head leaves in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_FU_P; i++) begin
            pop[i]      = hs && (grant == FU_IDX_W_LP'(i));
            push[i]     = fu_done_i[i] && ((cnt[i] != FULL_CNT) || pop[i]);
            drop[i]     = fu_done_i[i] && (cnt[i] == FULL_CNT) && !pop[i];
            cnt_next[i] = cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_FU_P; i++) begin
            if (push[i]) begin
                mem_data[i][wr_ptr[i]] <= fu_res_data_i[i*DATA_WIDTH_P +: DATA_WIDTH_P];
                mem_itag[i][wr_ptr[i]] <= fu_itag_i[i*ITAG_WIDTH_P +: ITAG_WIDTH_P];
                mem_tid[i][wr_ptr[i]]  <= fu_tid_i[i*TID_WIDTH_LP +: TID_WIDTH_LP];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_FU_P; i++) begin
                cnt[i]    <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            stall_q   <= '0;
            ovf_q     <= '0;
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_idx  <= '0;
            hold_data <= '0;
            hold_itag <= '0;
            hold_tid  <= '0;
            hold_fu   <= '0;
        end else begin
            for (int i = 0; i < NUM_FU_P; i++) begin
                cnt[i]     <= cnt_next[i];
                stall_q[i] <= (cnt_next[i] >= STALL_CNT);
                if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                if (drop[i]) ovf_q[i]  <= 1'b1;
            end
            if (hs) begin
                rr_ptr <= grant_inc;
                lock   <= 1'b0;
            end else if (wb_vld_o) begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end
            // Remember the last presented entry so outputs hold while empty.
            if (wb_vld_o) begin
                hold_data <= head_data;
                hold_itag <= head_itag;
                hold_tid  <= head_tid;
                hold_fu   <= grant;
            end
        end
    end

    assign wb_data_o     = wb_vld_o ? head_data : hold_data;
    assign wb_itag_o     = wb_vld_o ? head_itag : hold_itag;
    assign wb_tid_o      = wb_vld_o ? head_tid  : hold_tid;
    assign wb_fu_o       = wb_vld_o ? grant     : hold_fu;
    assign fu_wb_stall_o = stall_q;
    assign ovf_err_o     = ovf_q;

endmodule

// File: tb/tb_mrv1_wb_arb.sv
// Bench for mrv1_wb_arb: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the arbiter's rules.
module tb_mrv1_wb_arb;
    localparam int NF = 4;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int TW = 3;
    localparam int DEPTH = 2;
    localparam int SLACK = 1;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [NF-1:0]    fu_done_i = '0;
    logic [NF*DW-1:0] fu_res_data_i = '0;
    logic [NF*IW-1:0] fu_itag_i = '0;
    logic [NF*TW-1:0] fu_tid_i = '0;
    logic [NF-1:0]    fu_wb_stall_o;
    logic             wb_vld_o;
    logic             wb_rdy_i = 1'b0;
    logic [DW-1:0]    wb_data_o;
    logic [IW-1:0]    wb_itag_o;
    logic [TW-1:0]    wb_tid_o;
    logic [1:0]       wb_fu_o;
    logic [NF-1:0]    ovf_err_o;

    mrv1_wb_arb #(
        .NUM_FU_P(NF), .DATA_WIDTH_P(DW), .ITAG_WIDTH_P(IW), .NUM_THREADS_P(8),
        .FIFO_DEPTH_P(DEPTH), .SLACK_P(SLACK)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .fu_done_i(fu_done_i),
        .fu_res_data_i(fu_res_data_i), .fu_itag_i(fu_itag_i), .fu_tid_i(fu_tid_i),
        .fu_wb_stall_o(fu_wb_stall_o), .wb_vld_o(wb_vld_o), .wb_rdy_i(wb_rdy_i),
        .wb_data_o(wb_data_o), .wb_itag_o(wb_itag_o), .wb_tid_o(wb_tid_o),
        .wb_fu_o(wb_fu_o), .ovf_err_o(ovf_err_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: per-FU expected queues, entry = {tid, itag, data}
    logic [TW+IW+DW-1:0] exp_q [NF][$];
    int                  m_rr;
    bit                  m_lock;
    int                  m_lock_fu;
    logic [NF-1:0]       m_stall;
    logic [NF-1:0]       m_ovf;
    logic [TW+IW+DW-1:0] m_last;
    int                  m_last_fu;

    task automatic model_reset();
        for (int i = 0; i < NF; i++) exp_q[i].delete();
        m_rr = 0; m_lock = 0; m_lock_fu = 0;
        m_stall = '0; m_ovf = '0; m_last = '0; m_last_fu = 0;
    endtask

    // -1 when nothing is waiting
    function automatic int m_grant();
        if (m_lock) return m_lock_fu;
        for (int k = 0; k < NF; k++) begin
            int j;
            j = (m_rr + k) % NF;
            if (exp_q[j].size() > 0) return j;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int g;
        logic [TW+IW+DW-1:0] e;
        int efu;
        g   = m_grant();
        e   = (g >= 0) ? exp_q[g][0] : m_last;
        efu = (g >= 0) ? g : m_last_fu;
        chk("wb_vld", 64'(wb_vld_o), 64'(g >= 0));
        chk("wb_fu", 64'(wb_fu_o), 64'(efu));
        chk("wb_data", 64'(wb_data_o), 64'(e[DW-1:0]));
        chk("wb_itag", 64'(wb_itag_o), 64'(e[DW+IW-1:DW]));
        chk("wb_tid", 64'(wb_tid_o), 64'(e[DW+IW+TW-1:DW+IW]));
        chk("stall", 64'(fu_wb_stall_o), 64'(m_stall));
        chk("ovf", 64'(ovf_err_o), 64'(m_ovf));
    endtask

    task automatic model_step();
        int g;
        bit hs;
        bit full;
        logic [TW+IW+DW-1:0] e;
        g  = m_grant();
        hs = (g >= 0) && wb_rdy_i;
        if (g >= 0) begin
            m_last    = exp_q[g][0];
            m_last_fu = g;
        end
        for (int i = 0; i < NF; i++) begin
            full = (exp_q[i].size() == DEPTH);
            if (hs && g == i) e = exp_q[i].pop_front();
            if (fu_done_i[i]) begin
                if (!full || (hs && g == i))
                    exp_q[i].push_back({fu_tid_i[i*TW +: TW], fu_itag_i[i*IW +: IW],
                                        fu_res_data_i[i*DW +: DW]});
                else
                    m_ovf[i] = 1'b1;
            end
            m_stall[i] = (exp_q[i].size() >= DEPTH - SLACK);
        end
        if (hs) begin
            m_rr   = (g + 1) % NF;
            m_lock = 0;
        end else if (g >= 0) begin
            m_lock    = 1;
            m_lock_fu = g;
        end
    endtask

    // driver tasks
    task automatic set_fu(input int i, input logic [DW-1:0] d, input logic [IW-1:0] it,
                          input logic [TW-1:0] td);
        fu_res_data_i[i*DW +: DW] = d;
        fu_itag_i[i*IW +: IW]     = it;
        fu_tid_i[i*TW +: TW]      = td;
    endtask

    task automatic rand_fus();
        for (int i = 0; i < NF; i++)
            set_fu(i, $urandom, IW'($urandom_range(0, 7)), TW'($urandom_range(0, 7)));
    endtask

    task automatic drive_cycle(input logic [NF-1:0] done, input logic rdy);
        fu_done_i = done;
        wb_rdy_i  = rdy;
        @(negedge clk_i);
        check_outputs();
        model_step();
        @(posedge clk_i);
        #1;
        fu_done_i = '0;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        fu_done_i = '1;
        wb_rdy_i  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_vld", 64'(wb_vld_o), 64'(0));
        chk("rst_stall", 64'(fu_wb_stall_o), 64'(0));
        chk("rst_ovf", 64'(ovf_err_o), 64'(0));
        chk("rst_data", 64'(wb_data_o), 64'(0));
        chk("rst_fu", 64'(wb_fu_o), 64'(0));
        @(posedge clk_i);
        #1;
        fu_done_i = '0;
        rst_ni    = 1'b1;
    endtask

    initial begin
        // reset, then stays idle
        do_reset();
        drive_cycle('0, 1'b1);
        drive_cycle('0, 1'b0);

        // single result from FU1
        set_fu(1, 32'h1234, 3'd5, 3'd3);
        drive_cycle(4'b0010, 1'b1);
        chk("t2_vld", 64'(wb_vld_o), 64'(1));
        chk("t2_data", 64'(wb_data_o), 64'h1234);
        chk("t2_itag", 64'(wb_itag_o), 64'(5));
        chk("t2_tid", 64'(wb_tid_o), 64'(3));
        chk("t2_fu", 64'(wb_fu_o), 64'(1));
        drive_cycle('0, 1'b1);
        chk("t2_idle", 64'(wb_vld_o), 64'(0));
        chk("t2_hold", 64'(wb_data_o), 64'h1234);

        // round-robin over all four FUs; rr_ptr returns to 0
        do_reset();
        rand_fus();
        drive_cycle(4'hF, 1'b1);
        for (int k = 0; k < NF; k++) begin
            chk("t3_seq", 64'(wb_fu_o), 64'(k));
            drive_cycle('0, 1'b1);
        end
        chk("t3_idle", 64'(wb_vld_o), 64'(0));
        drive_cycle(4'b1001, 1'b0);
        chk("t3_rr0", 64'(wb_fu_o), 64'(0));
        drive_cycle('0, 1'b1);
        drive_cycle('0, 1'b1);

        // grant lock: FU2 held while FU0 arrives, then scan wraps to FU0
        set_fu(2, 32'hCAFE_0002, 3'd2, 3'd6);
        drive_cycle(4'b0100, 1'b0);
        set_fu(0, 32'hBEEF_0000, 3'd1, 3'd1);
        drive_cycle(4'b0001, 1'b0);
        drive_cycle('0, 1'b0);
        drive_cycle('0, 1'b0);
        chk("t4_lock_fu", 64'(wb_fu_o), 64'(2));
        chk("t4_lock_data", 64'(wb_data_o), 64'hCAFE_0002);
        drive_cycle('0, 1'b1);
        chk("t4_wrap_fu", 64'(wb_fu_o), 64'(0));
        chk("t4_wrap_data", 64'(wb_data_o), 64'hBEEF_0000);
        drive_cycle('0, 1'b1);

        // full / stall / overflow on FU1
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_fu(1, 32'h5100 + k, IW'(k), TW'(k));
            drive_cycle(4'b0010, 1'b0);
            if (k == 0) chk("t5_stall", 64'(fu_wb_stall_o[1]), 64'(1));
            if (k == 1) chk("t5_no_ovf", 64'(ovf_err_o[1]), 64'(0));
        end
        chk("t5_ovf", 64'(ovf_err_o[1]), 64'(1));
        repeat (3) drive_cycle('0, 1'b1);
        chk("t5_ovf_sticky", 64'(ovf_err_o[1]), 64'(1));

        // push into a full FIFO during its own handshake
        do_reset();
        set_fu(0, 32'hA, 3'd0, 3'd0);
        drive_cycle(4'b0001, 1'b0);
        set_fu(0, 32'hB, 3'd0, 3'd0);
        drive_cycle(4'b0001, 1'b0);
        set_fu(0, 32'hC, 3'd0, 3'd0);
        drive_cycle(4'b0001, 1'b1);
        chk("t6_ovf", 64'(ovf_err_o), 64'(0));
        chk("t6_head_b", 64'(wb_data_o), 64'hB);
        drive_cycle('0, 1'b1);
        chk("t6_head_c", 64'(wb_data_o), 64'hC);
        drive_cycle('0, 1'b1);
        chk("t6_idle", 64'(wb_vld_o), 64'(0));

        // random traffic with a reset in the middle
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            rand_fus();
            drive_cycle(NF'($urandom_range(0, 15)) & NF'($urandom_range(0, 15)),
                        $urandom_range(0, 3) != 0);
        end
        drive_cycle('0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
